// File: rtl/ptp_punch.sv
// PDP-6 paper tape punch (device 100): IO-bus CONO/CONI/DATAO responder with
// a one-character buffer, motor spin-up/idle timing and punch sequencing.
module ptp_punch #(
    parameter logic [6:0] DEVSEL       = 7'o20,
    parameter int         MOTOR_DELAY  = 1000,
    parameter int         PUNCH_CYCLES = 100,
    parameter int         MOTOR_IDLE   = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  iobus_ios,
    input  logic        iobus_iob_reset,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_iob_fm_status,
    input  logic        iobus_iob_fm_datai,
    input  logic [35:0] iobus_iob_in,
    output logic [35:0] iobus_iob_out,
    output logic [1:7]  iobus_pi_req,
    output logic [7:0]  punch_data,
    output logic        punch_strobe,
    output logic        motor_on
);

    localparam int CNT_MAX = (MOTOR_DELAY > PUNCH_CYCLES)
                           ? ((MOTOR_DELAY > MOTOR_IDLE) ? MOTOR_DELAY : MOTOR_IDLE)
                           : ((PUNCH_CYCLES > MOTOR_IDLE) ? PUNCH_CYCLES : MOTOR_IDLE);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counters hold "cycles remaining minus one", so a parameter of N gives N clocks in state.
    localparam logic [CW-1:0] DELAY_LD = CW'(MOTOR_DELAY - 1);
    localparam logic [CW-1:0] PUNCH_LD = CW'(PUNCH_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD  = CW'(MOTOR_IDLE - 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_SPINUP = 2'd1,
        S_READY  = 2'd2,
        S_PUNCH  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    pia_q, pia_d;
    logic          flag_q, flag_d;
    logic          busy_q, busy_d;
    logic          bin_q, bin_d;
    logic [7:0]    buf_q, buf_d;
    logic [7:0]    pdata_q, pdata_d;
    logic          strobe_q, strobe_d;
    logic          sel;

    logic unused_ok;
    assign unused_ok = ^{iobus_iob_fm_datai, iobus_iob_in[35:8]};

    assign sel = (iobus_ios == DEVSEL);

    // IO reset is a bus-wide reset and is not qualified by device select.
    always_ff @(posedge clk) begin
        if (!reset || iobus_iob_reset) begin
            state_q  <= S_OFF;
            cnt_q    <= '0;
            pia_q    <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            bin_q    <= 1'b0;
            buf_q    <= '0;
            pdata_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pia_q    <= pia_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            bin_q    <= bin_d;
            buf_q    <= buf_d;
            pdata_q  <= pdata_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pia_d    = pia_q;
        flag_d   = flag_q;
        busy_d   = busy_q;
        bin_d    = bin_q;
        buf_d    = buf_q;
        pdata_d  = pdata_q;
        strobe_d = 1'b0;

        case (state_q)
            S_OFF: begin
                if (busy_q) begin
                    state_d = S_SPINUP;
                    cnt_d   = DELAY_LD;
                end
            end
            S_SPINUP: begin
                if (cnt_q == '0) begin
                    state_d = S_READY;
                    cnt_d   = IDLE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READY: begin
                if (busy_q) begin
                    state_d  = S_PUNCH;
                    cnt_d    = PUNCH_LD;
                    pdata_d  = bin_q ? {2'b10, buf_q[5:0]} : buf_q;
                    strobe_d = 1'b1;
                    buf_d    = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_OFF;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PUNCH: begin
                // Busy dropping mid-punch (CONO clear) aborts without raising the flag.
                if (!busy_q) begin
                    state_d = S_READY;
                    cnt_d   = IDLE_LD;
                end else if (cnt_q == '0) begin
                    state_d = S_READY;
                    cnt_d   = IDLE_LD;
                    busy_d  = 1'b0;
                    flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase

        // Bus pulses are applied after the sequencer so a same-cycle CPU write wins.
        if (sel && iobus_cono_clear) begin
            pia_d  = '0;
            flag_d = 1'b0;
            busy_d = 1'b0;
            bin_d  = 1'b0;
        end
        if (sel && iobus_cono_set) begin
            pia_d  = pia_d | iobus_iob_in[2:0];
            flag_d = flag_d | iobus_iob_in[3];
            busy_d = busy_d | iobus_iob_in[4];
            bin_d  = bin_d | iobus_iob_in[5];
        end
        if (sel && iobus_datao_clear) begin
            buf_d = '0;
        end
        if (sel && iobus_datao_set) begin
            buf_d  = buf_d | iobus_iob_in[7:0];
            busy_d = 1'b1;
            flag_d = 1'b0;
        end
    end

    always_comb begin
        motor_on      = (state_q != S_OFF);
        punch_data    = pdata_q;
        punch_strobe  = strobe_q;
        iobus_iob_out = '0;
        if (sel && iobus_iob_fm_status) begin
            iobus_iob_out[5:0] = {bin_q, busy_q, flag_q, pia_q};
        end
        for (int n = 1; n <= 7; n++) begin
            iobus_pi_req[n] = flag_q && (pia_q == 3'(n));
        end
    end

endmodule
